// File: rtl/mem_stage.sv
// Memory stage: turns ALU results into pass-through results or data-memory
// accesses, and hands one result per instruction to writeback.
module mem_stage #(
  parameter int DATA_W = 64,
  parameter int RD_W   = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] alu_res_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic [1:0]        mem_op_i,
  input  logic [1:0]        mem_size_i,
  input  logic              mem_unsigned_i,
  input  logic [RD_W-1:0]   rd_i,
  input  logic              rd_we_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [DATA_W-1:0] dmem_addr_o,
  output logic [7:0]        dmem_be_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [RD_W-1:0]   wb_rd_o,
  output logic              wb_we_o,
  output logic              misaligned_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP,
    OUT
  } state_t;

  typedef struct packed {
    logic [1:0]        op;
    logic [1:0]        size;
    logic              uns;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] sdata;
    logic [RD_W-1:0]   rd;
    logic              we;
    logic              mis;
  } req_t;

  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;

  state_t state, state_nxt;
  req_t   req_q;
  logic [DATA_W-1:0] res_q;

  logic       accept;
  logic       in_mem;
  logic       in_mis;
  logic       in_we;
  logic [2:0] in_amask;
  state_t     in_next;

  logic [5:0]        sh;
  logic [7:0]        size_be;
  logic [DATA_W-1:0] rep;
  logic [DATA_W-1:0] ld_sh;
  logic [DATA_W-1:0] ld_ext;

  assign ready_o = (state == IDLE) ||
                   ((state == OUT) && wb_ready_i);
  assign accept  = valid_i && ready_o;

  always_comb begin
    in_amask = 3'b000;
    unique case (mem_size_i)
      2'd0: in_amask = 3'b000;
      2'd1: in_amask = 3'b001;
      2'd2: in_amask = 3'b011;
      2'd3: in_amask = 3'b111;
    endcase
  end

  assign in_mem = (mem_op_i == OP_LOAD) ||
                  (mem_op_i == OP_STORE);
  assign in_mis = in_mem &&
                  (|(alu_res_i[2:0] & in_amask));
  assign in_we  = rd_we_i &&
                  (mem_op_i != OP_STORE) && !in_mis;
  assign in_next = (in_mem && !in_mis) ? REQ : OUT;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (valid_i) state_nxt = in_next;
      end
      REQ: begin
        if (dmem_gnt_i)
          state_nxt = (req_q.op == OP_STORE) ? OUT : WAIT_RSP;
      end
      WAIT_RSP: begin
        if (dmem_rvalid_i) state_nxt = OUT;
      end
      OUT: begin
        if (wb_ready_i)
          state_nxt = valid_i ? in_next : IDLE;
      end
    endcase
  end

  assign sh = {req_q.addr[2:0], 3'b000};

  always_comb begin
    size_be = 8'h00;
    rep     = '0;
    unique case (req_q.size)
      2'd0: begin
        size_be = 8'h01;
        rep     = {8{req_q.sdata[7:0]}};
      end
      2'd1: begin
        size_be = 8'h03;
        rep     = {4{req_q.sdata[15:0]}};
      end
      2'd2: begin
        size_be = 8'h0F;
        rep     = {2{req_q.sdata[31:0]}};
      end
      2'd3: begin
        size_be = 8'hFF;
        rep     = req_q.sdata;
      end
    endcase
  end

  // Lane data lands at bit 0 after the shift; truncate then extend.
  assign ld_sh = dmem_rdata_i >> sh;

  always_comb begin
    ld_ext = ld_sh;
    unique case (req_q.size)
      2'd0: ld_ext = req_q.uns ?
        {56'd0, ld_sh[7:0]} :
        {{56{ld_sh[7]}}, ld_sh[7:0]};
      2'd1: ld_ext = req_q.uns ?
        {48'd0, ld_sh[15:0]} :
        {{48{ld_sh[15]}}, ld_sh[15:0]};
      2'd2: ld_ext = req_q.uns ?
        {32'd0, ld_sh[31:0]} :
        {{32{ld_sh[31]}}, ld_sh[31:0]};
      2'd3: ld_ext = ld_sh;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q <= '0;
      res_q <= '0;
    end else if (accept) begin
      req_q.op    <= mem_op_i;
      req_q.size  <= mem_size_i;
      req_q.uns   <= mem_unsigned_i;
      req_q.addr  <= alu_res_i;
      req_q.sdata <= store_data_i;
      req_q.rd    <= rd_i;
      req_q.we    <= in_we;
      req_q.mis   <= in_mis;
      res_q       <= alu_res_i;
    end else if ((state == WAIT_RSP) && dmem_rvalid_i) begin
      res_q <= ld_ext;
    end
  end

  always_comb begin
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_be_o    = 8'h00;
    dmem_wdata_o = '0;
    if (state == REQ) begin
      dmem_req_o   = 1'b1;
      dmem_we_o    = (req_q.op == OP_STORE);
      dmem_addr_o  = {req_q.addr[DATA_W-1:3], 3'b000};
      dmem_be_o    = size_be << req_q.addr[2:0];
      dmem_wdata_o = rep << sh;
    end
  end

  always_comb begin
    wb_valid_o   = 1'b0;
    wb_data_o    = '0;
    wb_rd_o      = '0;
    wb_we_o      = 1'b0;
    misaligned_o = 1'b0;
    if (state == OUT) begin
      wb_valid_o   = 1'b1;
      wb_data_o    = res_q;
      wb_rd_o      = req_q.rd;
      wb_we_o      = req_q.we;
      misaligned_o = req_q.mis;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table plus hand-written
// sequences for streaming, gnt stalls, writeback stalls and reset.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic [63:0] alu_res_i;
  logic [63:0] store_data_i;
  logic [1:0]  mem_op_i;
  logic [1:0]  mem_size_i;
  logic        mem_unsigned_i;
  logic [4:0]  rd_i;
  logic        rd_we_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [63:0] dmem_addr_o;
  logic [7:0]  dmem_be_o;
  logic [63:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [63:0] dmem_rdata_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [63:0] wb_data_o;
  logic [4:0]  wb_rd_o;
  logic        wb_we_o;
  logic        misaligned_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .valid_i(valid_i), .ready_o(ready_o),
    .alu_res_i(alu_res_i), .store_data_i(store_data_i),
    .mem_op_i(mem_op_i), .mem_size_i(mem_size_i),
    .mem_unsigned_i(mem_unsigned_i),
    .rd_i(rd_i), .rd_we_i(rd_we_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
    .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o),
    .wb_we_o(wb_we_o), .misaligned_o(misaligned_o)
  );

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] sdata;
    logic [63:0] rdata;
    logic        req;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic [63:0] data;
    logic        we;
    logic        mis;
    int          lat;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    int   lat;
    rst_ni = 1'b0; valid_i = 1'b0; alu_res_i = '0;
    store_data_i = '0; mem_op_i = '0; mem_size_i = '0;
    mem_unsigned_i = 1'b0; rd_i = '0; rd_we_i = 1'b0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    dmem_rdata_i = '0; wb_ready_i = 1'b1;

    tbl[0]  = '{2'd0, 2'd0, 1'b0, 64'h1234, 64'h0, 64'h0,
                1'b0, 8'h00, 64'h0, 64'h1234, 1'b1, 1'b0, 1};
    tbl[1]  = '{2'd1, 2'd0, 1'b0, 64'h1003, 64'h0,
                64'h0000_0000_8000_0000,
                1'b1, 8'h08, 64'h0,
                64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0, 3};
    tbl[2]  = '{2'd1, 2'd0, 1'b1, 64'h1003, 64'h0,
                64'h0000_0000_8000_0000,
                1'b1, 8'h08, 64'h0, 64'h80, 1'b1, 1'b0, 3};
    tbl[3]  = '{2'd1, 2'd1, 1'b0, 64'h10A6, 64'h0,
                64'h8001_0000_0000_0000,
                1'b1, 8'hC0, 64'h0,
                64'hFFFF_FFFF_FFFF_8001, 1'b1, 1'b0, 3};
    tbl[4]  = '{2'd1, 2'd2, 1'b1, 64'h2004, 64'h0,
                64'hF000_0000_1111_1111,
                1'b1, 8'hF0, 64'h0,
                64'h0000_0000_F000_0000, 1'b1, 1'b0, 3};
    tbl[5]  = '{2'd1, 2'd2, 1'b0, 64'h2004, 64'h0,
                64'hF000_0000_1111_1111,
                1'b1, 8'hF0, 64'h0,
                64'hFFFF_FFFF_F000_0000, 1'b1, 1'b0, 3};
    tbl[6]  = '{2'd1, 2'd3, 1'b1, 64'h4000, 64'h0,
                64'h8123_4567_89AB_CDEF,
                1'b1, 8'hFF, 64'h0,
                64'h8123_4567_89AB_CDEF, 1'b1, 1'b0, 3};
    tbl[7]  = '{2'd2, 2'd0, 1'b0, 64'h5005,
                64'h1122_3344_5566_7777, 64'h0,
                1'b1, 8'h20, 64'h7777_7700_0000_0000,
                64'h5005, 1'b0, 1'b0, 2};
    tbl[8]  = '{2'd2, 2'd2, 1'b0, 64'h6004,
                64'hDEAD_BEEF_CAFE_F00D, 64'h0,
                1'b1, 8'hF0, 64'hCAFE_F00D_0000_0000,
                64'h6004, 1'b0, 1'b0, 2};
    tbl[9]  = '{2'd1, 2'd2, 1'b0, 64'h3002, 64'h0, 64'h0,
                1'b0, 8'h00, 64'h0, 64'h3002, 1'b0, 1'b1, 1};
    tbl[10] = '{2'd2, 2'd3, 1'b0, 64'h7004, 64'h55, 64'h0,
                1'b0, 8'h00, 64'h0, 64'h7004, 1'b0, 1'b1, 1};
    tbl[11] = '{2'd3, 2'd1, 1'b0, 64'hBEEF, 64'h0, 64'h0,
                1'b0, 8'h00, 64'h0, 64'hBEEF, 1'b1, 1'b0, 1};
    tbl[12] = '{2'd1, 2'd1, 1'b0, 64'h1001, 64'h0, 64'h0,
                1'b0, 8'h00, 64'h0, 64'h1001, 1'b0, 1'b1, 1};

    #12;
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_outs", 64'({dmem_req_o, dmem_we_o, wb_valid_o,
          wb_we_o, misaligned_o}), 64'd0);
    check("rst_bus", dmem_addr_o | dmem_wdata_o | wb_data_o
          | 64'(dmem_be_o) | 64'(wb_rd_o), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;

    // Table: gnt and rvalid held high, so latencies are the minimum.
    dmem_gnt_i = 1'b1;
    dmem_rvalid_i = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      valid_i = 1'b1;
      mem_op_i = tbl[i].op;
      mem_size_i = tbl[i].size;
      mem_unsigned_i = tbl[i].uns;
      alu_res_i = tbl[i].addr;
      store_data_i = tbl[i].sdata;
      dmem_rdata_i = tbl[i].rdata;
      rd_i = 5'(i + 1);
      rd_we_i = 1'b1;
      #1 check($sformatf("v%0d_ready", i), 64'(ready_o), 64'd1);
      seen = 1'b0;
      lat = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        valid_i = 1'b0;
        lat++;
        if (dmem_req_o && !seen) begin
          seen = 1'b1;
          check($sformatf("v%0d_addr", i), dmem_addr_o,
                {tbl[i].addr[63:3], 3'b000});
          check($sformatf("v%0d_be", i), 64'(dmem_be_o),
                64'(tbl[i].be));
          check($sformatf("v%0d_dwe", i), 64'(dmem_we_o),
                64'(tbl[i].op == 2'd2));
          if (tbl[i].op == 2'd2)
            check($sformatf("v%0d_wdata", i), dmem_wdata_o,
                  tbl[i].wdata);
        end
        if (wb_valid_o) break;
      end
      check($sformatf("v%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
      check($sformatf("v%0d_req", i), 64'(seen), 64'(tbl[i].req));
      check($sformatf("v%0d_data", i), wb_data_o, tbl[i].data);
      check($sformatf("v%0d_we", i), 64'(wb_we_o), 64'(tbl[i].we));
      check($sformatf("v%0d_mis", i), 64'(misaligned_o),
            64'(tbl[i].mis));
      check($sformatf("v%0d_rd", i), 64'(wb_rd_o), 64'(i + 1));
    end
    @(negedge clk);
    check("idle_after_tbl", 64'({wb_valid_o, ready_o}), 64'b01);

    // Back-to-back op none streams one per cycle.
    mem_op_i = 2'd0; rd_i = 5'd7; rd_we_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        check("b2b_valid", 64'(wb_valid_o), 64'd1);
        check("b2b_data", wb_data_o, 64'h100 + 64'(k - 1));
      end
      valid_i = (k < 4);
      alu_res_i = 64'h100 + 64'(k);
      @(negedge clk);
    end
    check("b2b_drain", 64'(wb_valid_o), 64'd0);

    // Store half with gnt held off for three cycles.
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    valid_i = 1'b1; mem_op_i = 2'd2; mem_size_i = 2'd1;
    alu_res_i = 64'h2006; store_data_i = 64'hABCD;
    @(negedge clk);
    valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("st_req", 64'(dmem_req_o), 64'd1);
      check("st_we", 64'(dmem_we_o), 64'd1);
      check("st_addr", dmem_addr_o, 64'h2000);
      check("st_be", 64'(dmem_be_o), 64'hC0);
      check("st_wdata", 64'(dmem_wdata_o[63:48]), 64'hABCD);
      if (k == 3) dmem_gnt_i = 1'b1;
      @(negedge clk);
    end
    dmem_gnt_i = 1'b0;
    check("st_out", 64'({wb_valid_o, wb_we_o, dmem_req_o}), 64'b100);
    check("st_data", wb_data_o, 64'h2006);
    @(negedge clk);

    // Writeback stall: outputs held, new valid ignored.
    wb_ready_i = 1'b0;
    valid_i = 1'b1; mem_op_i = 2'd0; alu_res_i = 64'h55;
    rd_i = 5'd3; rd_we_i = 1'b1;
    @(negedge clk);
    alu_res_i = 64'h99; rd_i = 5'd9;
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", 64'(wb_valid_o), 64'd1);
      check("stall_ready", 64'(ready_o), 64'd0);
      check("stall_data", wb_data_o, 64'h55);
      check("stall_rd", 64'(wb_rd_o), 64'd3);
      @(negedge clk);
    end
    valid_i = 1'b0; wb_ready_i = 1'b1;
    @(negedge clk);
    check("stall_exit", 64'({wb_valid_o, ready_o}), 64'b01);

    // Reset while waiting for load data; stray rvalid afterwards.
    dmem_gnt_i = 1'b1;
    valid_i = 1'b1; mem_op_i = 2'd1; mem_size_i = 2'd3;
    alu_res_i = 64'h8000; dmem_rdata_i = 64'hDEAD;
    @(negedge clk);
    valid_i = 1'b0;
    check("rr_req", 64'(dmem_req_o), 64'd1);
    @(negedge clk);
    check("rr_wait", 64'({dmem_req_o, wb_valid_o, ready_o}), 64'd0);
    rst_ni = 1'b0;
    #1;
    check("rr_ready", 64'(ready_o), 64'd1);
    check("rr_outs", 64'({dmem_req_o, wb_valid_o}), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1; dmem_rvalid_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rr_stray", 64'({wb_valid_o, ready_o, dmem_req_o}),
            64'b010);
      check("rr_data", wb_data_o, 64'd0);
    end
    dmem_rvalid_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the 64-bit ALU (execute).
- Consumes the ALU result as either a pass-through result or a load/store effective address.
- Performs the data-memory access over a req/gnt/rvalid interface, aligns and sign- or zero-extends load data, and forms store byte enables.
- Hands one result per instruction to writeback over a valid/ready handshake.

Parameters:
- DATA_W, 64, datapath width; only 64 is supported.
- RD_W, 5, destination register index width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- valid_i  in  1  upstream instruction valid.
- ready_o  out  1  stage can accept this cycle.
- alu_res_i  in  DATA_W  ALU result / effective address.
- store_data_i  in  DATA_W  rs2 value for stores.
- mem_op_i  in  2  0 = none, 1 = load, 2 = store, 3 = reserved (treated as none).
- mem_size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = dword.
- mem_unsigned_i  in  1  zero-extend load when 1.
- rd_i  in  RD_W  destination register.
- rd_we_i  in  1  writeback enable.
- dmem_req_o  out  1  memory request.
- dmem_we_o  out  1  1 = store.
- dmem_addr_o  out  DATA_W  doubleword-aligned address.
- dmem_be_o  out  8  byte enables.
- dmem_wdata_o  out  DATA_W  lane-positioned store data.
- dmem_gnt_i  in  1  request accepted.
- dmem_rvalid_i  in  1  load data valid.
- dmem_rdata_i  in  DATA_W  load data.
- wb_valid_o  out  1  result valid to writeback.
- wb_ready_i  in  1  writeback accepts.
- wb_data_o  out  DATA_W  result.
- wb_rd_o  out  RD_W  destination.
- wb_we_o  out  1  register write enable.
- misaligned_o  out  1  misaligned-access flag; qualified by wb_valid_o.

Behaviour:
- Reset: FSM goes to IDLE asynchronously. Every output is 0 except ready_o, which is 1 in IDLE. All registered fields are cleared.
- FSM states: IDLE, REQ, WAIT_RSP, OUT.
- ready_o = (state == IDLE) or (state == OUT and wb_ready_i). Transfer occurs when valid_i && ready_o.
- On transfer, latch all inputs, then branch on the latched op:
  - Op none/reserved: wb_data = alu_res_i; next state OUT.
  - Load/store, aligned (addr[2:0] mod size-bytes == 0): next state REQ.
  - Load/store, misaligned: next state OUT with wb_we_o = 0, misaligned_o = 1, wb_data_o = address. No memory request is issued.
- REQ state:
  - dmem_req_o = 1; dmem_addr_o = {addr[63:3], 3'b000}.
  - dmem_be_o = size mask (0x01 / 0x03 / 0x0F / 0xFF) << addr[2:0].
  - dmem_wdata_o = store_data replicated across lanes, shifted left by addr[2:0] × 8.
  - dmem_we_o = 1 for stores, 0 for loads.
  - All dmem outputs are held stable until dmem_gnt_i.
  - On gnt: a store goes to OUT with wb_we_o = 0 and wb_data_o = address; a load goes to WAIT_RSP.
- Memory ordering: dmem_rvalid_i arrives at least one cycle after gnt. rvalid is ignored in every state except WAIT_RSP.
- WAIT_RSP, on rvalid:
  - Shift rdata right by addr[2:0] × 8.
  - Truncate to size, then sign- or zero-extend per mem_unsigned_i. A dword load ignores the unsigned flag.
  - Register the result as wb_data; next state OUT.
- OUT state:
  - wb_valid_o = 1; wb_data_o, wb_rd_o, wb_we_o and misaligned_o are held stable until wb_ready_i.
  - On wb_ready_i, if a new transfer is also present, process it as from IDLE (back-to-back, no bubble). Otherwise go to IDLE.
- Latency from acceptance at cycle N:
  - Op none or misaligned: wb_valid_o at N+1.
  - Store with immediate gnt: wb_valid_o at N+2.
  - Load with immediate gnt and rvalid one cycle later: wb_valid_o at N+3.
- wb_we_o = rd_we_i && (op == none or op == load) && !misaligned.
- Reset mid-access: the FSM abandons the access. A stray rvalid arriving after reset is ignored.
- One instruction is in flight at most; throughput is 1 per cycle for op none when wb_ready_i is held high.

Test Plan:
- Op none, alu_res_i = 0x1234, rd_i = 7, rd_we_i = 1, wb_ready_i = 1 -> wb_valid_o next cycle with wb_data_o = 0x1234, wb_rd_o = 7, wb_we_o = 1. Back-to-back ops stream at 1 per cycle.
- Load byte signed, addr 0x1003, rdata 0x00000000_80000000 -> be = 0x08, dmem_addr_o = 0x1000, wb_data_o = 0xFFFF_FFFF_FFFF_FF80. Same with mem_unsigned_i = 1 -> 0x80.
- Store half, addr 0x2006, store_data 0xABCD, gnt delayed 3 cycles -> dmem outputs stable for all 4 cycles, be = 0xC0, wdata[63:48] = 0xABCD, then wb_valid_o with wb_we_o = 0.
- Load word at addr 0x3002 -> no dmem_req_o, wb_valid_o next cycle with misaligned_o = 1, wb_we_o = 0.
- wb_ready_i low for 5 cycles in OUT -> wb_* held stable, ready_o = 0, valid_i ignored.
- rst_ni pulsed low in WAIT_RSP, then rvalid asserted -> outputs 0, FSM in IDLE, rvalid ignored, ready_o = 1.
